// File: rtl/mesh_ni_pkg.sv
// rtl/mesh_ni_pkg.sv - shared types, flit field offsets and width helpers for mesh_ni
package mesh_ni_pkg;

  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  // Flit layout, LSB first: data, src_y, src_x, last
  localparam int DATA_LSB = 0;

  function automatic int coord_w(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

  function automatic int calc_fw(input int pw, input int xw, input int yw);
    return pw + 1 + xw + yw;
  endfunction

  function automatic int src_y_lsb(input int pw);
    return pw;
  endfunction

  function automatic int src_x_lsb(input int pw, input int yw);
    return pw + yw;
  endfunction

  function automatic int last_bit(input int fw);
    return fw - 1;
  endfunction

endpackage

// File: rtl/mesh_ni_if.sv
// rtl/mesh_ni_if.sv - message and router-local-port bundle; slave = network interface side
interface mesh_ni_if
  import mesh_ni_pkg::*;
#(
  parameter int PW        = 8,
  parameter int MSG_FLITS = 4,
  parameter int X_SIZE    = 4,
  parameter int Y_SIZE    = 4
);
  localparam int XW = coord_w(X_SIZE);
  localparam int YW = coord_w(Y_SIZE);
  localparam int FW = calc_fw(PW, XW, YW);

  logic                    i_tx_valid;
  logic [XW-1:0]           i_tx_dst_x;
  logic [YW-1:0]           i_tx_dst_y;
  logic [MSG_FLITS*PW-1:0] i_tx_msg;
  logic                    o_tx_ready;
  logic                    o_net_valid;
  logic [XW-1:0]           o_net_dst_x;
  logic [YW-1:0]           o_net_dst_y;
  logic [FW-1:0]           o_net_payload;
  logic                    i_net_ready;
  logic                    i_net_valid;
  logic [XW-1:0]           i_net_dst_x;
  logic [YW-1:0]           i_net_dst_y;
  logic [FW-1:0]           i_net_payload;
  logic                    o_net_ready;
  logic                    o_rx_valid;
  logic [XW-1:0]           o_rx_src_x;
  logic [YW-1:0]           o_rx_src_y;
  logic [MSG_FLITS*PW-1:0] o_rx_msg;
  logic                    i_rx_ready;

  modport slave (
    input  i_tx_valid, i_tx_dst_x, i_tx_dst_y, i_tx_msg, i_net_ready,
    input  i_net_valid, i_net_dst_x, i_net_dst_y, i_net_payload, i_rx_ready,
    output o_tx_ready, o_net_valid, o_net_dst_x, o_net_dst_y, o_net_payload,
    output o_net_ready, o_rx_valid, o_rx_src_x, o_rx_src_y, o_rx_msg
  );

  modport master (
    output i_tx_valid, i_tx_dst_x, i_tx_dst_y, i_tx_msg, i_net_ready,
    output i_net_valid, i_net_dst_x, i_net_dst_y, i_net_payload, i_rx_ready,
    input  o_tx_ready, o_net_valid, o_net_dst_x, o_net_dst_y, o_net_payload,
    input  o_net_ready, o_rx_valid, o_rx_src_x, o_rx_src_y, o_rx_msg
  );

endinterface

// File: rtl/mesh_ni_rx_assembler.sv
// rtl/mesh_ni_rx_assembler.sv - per-source flit reassembly and message output register
// MESH_NI_CHECK_EN adds misroute / short-message detection on err.
module mesh_ni_rx_assembler
  import mesh_ni_pkg::*;
#(
  parameter  int PW        = 8,
  parameter  int MSG_FLITS = 4,
  parameter  int X_SIZE    = 4,
  parameter  int Y_SIZE    = 4,
  localparam int XW        = coord_w(X_SIZE),
  localparam int YW        = coord_w(Y_SIZE),
  localparam int FW        = calc_fw(PW, XW, YW)
) (
  input  logic                    clk,
  input  logic                    rst_n,
`ifdef MESH_NI_CHECK_EN
  input  logic [XW-1:0]           coord_x,
  input  logic [YW-1:0]           coord_y,
  input  logic [XW-1:0]           net_dst_x,
  input  logic [YW-1:0]           net_dst_y,
  output logic                    err,
`endif
  input  logic                    net_valid,
  input  logic [FW-1:0]           net_payload,
  output logic                    net_ready,
  output logic                    rx_valid,
  output logic [XW-1:0]           rx_src_x,
  output logic [YW-1:0]           rx_src_y,
  output logic [MSG_FLITS*PW-1:0] rx_msg,
  input  logic                    rx_ready
);
  localparam int NSRC = X_SIZE * Y_SIZE;
  localparam int SW   = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int CW   = (MSG_FLITS > 1) ? $clog2(MSG_FLITS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(MSG_FLITS - 1);

  logic [PW-1:0]           data;
  logic [XW-1:0]           src_x;
  logic [YW-1:0]           src_y;
  logic                    is_last;
  logic [SW-1:0]           src;
  logic                    accept;
  logic                    misroute;
  logic                    take;
  logic [MSG_FLITS*PW-1:0] full_msg;
`ifdef MESH_NI_CHECK_EN
  logic                    cnt_ok;
`endif

  assign data    = net_payload[DATA_LSB +: PW];
  assign src_y   = net_payload[src_y_lsb(PW) +: YW];
  assign src_x   = net_payload[src_x_lsb(PW, YW) +: XW];
  assign is_last = net_payload[last_bit(FW)];
  assign src     = SW'(int'(src_y) * X_SIZE + int'(src_x));

  // Only a held, undrained message can stall the router; never looks at net_valid.
  assign net_ready = !rx_valid || rx_ready;
  assign accept    = net_valid && net_ready;
  assign take      = accept && !misroute;

`ifdef MESH_NI_CHECK_EN
  assign misroute = (net_dst_x != coord_x) || (net_dst_y != coord_y);
`else
  assign misroute = 1'b0;
`endif

  generate
    if (MSG_FLITS > 1) begin : g_buf
      logic [(MSG_FLITS-1)*PW-1:0] buf_q [NSRC];
      logic [CW-1:0]               cnt_q [NSRC];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < NSRC; i++) cnt_q[i] <= '0;
        end else if (take) begin
          if (is_last) begin
            cnt_q[src] <= '0;
          end else if (cnt_q[src] != LAST_CNT) begin
            buf_q[src][cnt_q[src]*PW +: PW] <= data;
            cnt_q[src]                      <= cnt_q[src] + 1'b1;
          end
        end
      end

      assign full_msg = {data, buf_q[src]};
`ifdef MESH_NI_CHECK_EN
      assign cnt_ok = (cnt_q[src] == LAST_CNT);
`endif
    end else begin : g_single
      assign full_msg = data;
`ifdef MESH_NI_CHECK_EN
      assign cnt_ok = 1'b1;
`endif
    end
  endgenerate

  // A completion in the drain cycle reloads the register: back-to-back delivery.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_valid <= 1'b0;
    end else if (take && is_last) begin
      rx_valid <= 1'b1;
    end else if (rx_ready) begin
      rx_valid <= 1'b0;
    end
    if (take && is_last) begin
      rx_msg   <= full_msg;
      rx_src_x <= src_x;
      rx_src_y <= src_y;
    end
  end

`ifdef MESH_NI_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (accept && (misroute || (is_last && !cnt_ok))) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: rtl/mesh_ni.sv
// rtl/mesh_ni.sv - mesh tile network interface: TX message serializer and RX reassembler
// MESH_NI_CHECK_EN adds the sticky o_err output.
module mesh_ni
  import mesh_ni_pkg::*;
#(
  parameter  int PW        = 8,
  parameter  int MSG_FLITS = 4,
  parameter  int X_SIZE    = 4,
  parameter  int Y_SIZE    = 4,
  localparam int XW        = coord_w(X_SIZE),
  localparam int YW        = coord_w(Y_SIZE),
  localparam int FW        = calc_fw(PW, XW, YW)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [XW-1:0] i_coord_x,
  input  logic [YW-1:0] i_coord_y,
`ifdef MESH_NI_CHECK_EN
  output logic          o_err,
`endif
  mesh_ni_if.slave      bus
);
  localparam int CW = (MSG_FLITS > 1) ? $clog2(MSG_FLITS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(MSG_FLITS - 1);

  tx_state_t               state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [MSG_FLITS*PW-1:0] msg_q;
  logic [XW-1:0]           dst_x_q;
  logic [YW-1:0]           dst_y_q;
  logic                    tx_accept;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
    if (tx_accept) begin
      msg_q   <= bus.i_tx_msg;
      dst_x_q <= bus.i_tx_dst_x;
      dst_y_q <= bus.i_tx_dst_y;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    tx_accept       = 1'b0;
    bus.o_tx_ready  = 1'b0;
    bus.o_net_valid = 1'b0;
    case (state_q)
      TX_IDLE: begin
        bus.o_tx_ready = rst_n;
        if (rst_n && bus.i_tx_valid) begin
          tx_accept = 1'b1;
          cnt_d     = '0;
          state_d   = TX_SEND;
        end
      end
      TX_SEND: begin
        bus.o_net_valid = 1'b1;
        if (bus.i_net_ready) begin
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            state_d = TX_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  assign bus.o_net_dst_x   = dst_x_q;
  assign bus.o_net_dst_y   = dst_y_q;
  assign bus.o_net_payload = {cnt_q == LAST_CNT, i_coord_x, i_coord_y, msg_q[cnt_q*PW +: PW]};

  mesh_ni_rx_assembler #(
    .PW       (PW),
    .MSG_FLITS(MSG_FLITS),
    .X_SIZE   (X_SIZE),
    .Y_SIZE   (Y_SIZE)
  ) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef MESH_NI_CHECK_EN
    .coord_x    (i_coord_x),
    .coord_y    (i_coord_y),
    .net_dst_x  (bus.i_net_dst_x),
    .net_dst_y  (bus.i_net_dst_y),
    .err        (o_err),
`endif
    .net_valid  (bus.i_net_valid),
    .net_payload(bus.i_net_payload),
    .net_ready  (bus.o_net_ready),
    .rx_valid   (bus.o_rx_valid),
    .rx_src_x   (bus.o_rx_src_x),
    .rx_src_y   (bus.o_rx_src_y),
    .rx_msg     (bus.o_rx_msg),
    .rx_ready   (bus.i_rx_ready)
  );

endmodule

// File: tb/tb_mesh_ni.sv
// tb/tb_mesh_ni.sv - directed self-checking bench for mesh_ni at tile (1,2), PW=8, MSG_FLITS=4
// MESH_NI_CHECK_EN also exercises o_err.
module tb_mesh_ni;
  localparam int PW = 8;
  localparam int MF = 4;
  localparam int XS = 4;
  localparam int YS = 4;
  localparam int FW = 13;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] cx    = 2'd1;
  logic [1:0] cy    = 2'd2;
  int         n_checks = 0;
  int         n_errors = 0;
`ifdef MESH_NI_CHECK_EN
  logic       err;
`endif

  always #5 clk = ~clk;

  mesh_ni_if #(.PW(PW), .MSG_FLITS(MF), .X_SIZE(XS), .Y_SIZE(YS)) bus ();

  mesh_ni #(.PW(PW), .MSG_FLITS(MF), .X_SIZE(XS), .Y_SIZE(YS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_coord_x(cx),
    .i_coord_y(cy),
`ifdef MESH_NI_CHECK_EN
    .o_err    (err),
`endif
    .bus      (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FW-1:0] mk(input logic last, input logic [1:0] sx,
                                       input logic [1:0] sy, input logic [7:0] d);
    return {last, sx, sy, d};
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] m, input int k);
    return m[k*8 +: 8];
  endfunction

  // Offer one flit to the RX side, wait (bounded) for o_net_ready, complete the handshake.
  task automatic net_send(input logic [FW-1:0] p, input logic [1:0] dx, input logic [1:0] dy);
    int n;
    bus.i_net_valid   = 1'b1;
    bus.i_net_payload = p;
    bus.i_net_dst_x   = dx;
    bus.i_net_dst_y   = dy;
    n = 0;
    while (!bus.o_net_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.o_net_ready) check("net_ready_timeout", 64'(bus.o_net_ready), 64'd1);
    tick();
    bus.i_net_valid = 1'b0;
  endtask

  task automatic check_rx(input string tag, input logic [31:0] m, input logic [1:0] sx,
                          input logic [1:0] sy);
    check({tag, "_valid"}, 64'(bus.o_rx_valid), 64'd1);
    check({tag, "_msg"},   64'(bus.o_rx_msg),   64'(m));
    check({tag, "_src_x"}, 64'(bus.o_rx_src_x), 64'(sx));
    check({tag, "_src_y"}, 64'(bus.o_rx_src_y), 64'(sy));
  endtask

  // Accept a message with no back-pressure and check the four flits on consecutive cycles.
  task automatic tx_run(input string tag, input logic [31:0] m, input logic [1:0] dx,
                        input logic [1:0] dy);
    bus.i_net_ready = 1'b1;
    bus.i_tx_msg    = m;
    bus.i_tx_dst_x  = dx;
    bus.i_tx_dst_y  = dy;
    bus.i_tx_valid  = 1'b1;
    tick();
    bus.i_tx_valid  = 1'b0;
    for (int k = 0; k < MF; k++) begin
      check($sformatf("%s_valid%0d", tag, k), 64'(bus.o_net_valid), 64'd1);
      check($sformatf("%s_flit%0d", tag, k), 64'(bus.o_net_payload),
            64'(mk(k == MF-1, 2'd1, 2'd2, byte_of(m, k))));
      check($sformatf("%s_dst%0d", tag, k), 64'({bus.o_net_dst_x, bus.o_net_dst_y}),
            64'({dx, dy}));
      check($sformatf("%s_txrdy%0d", tag, k), 64'(bus.o_tx_ready), 64'd0);
      tick();
    end
    check({tag, "_txrdy_back"}, 64'(bus.o_tx_ready), 64'd1);
    check({tag, "_idle_valid"}, 64'(bus.o_net_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] ms;
    int          idx;
    bit          rdy;
    ma = 32'h44332211;
    mb = 32'h88776655;
    bus.i_tx_valid    = 1'b0;
    bus.i_tx_dst_x    = '0;
    bus.i_tx_dst_y    = '0;
    bus.i_tx_msg      = '0;
    bus.i_net_ready   = 1'b0;
    bus.i_net_valid   = 1'b0;
    bus.i_net_dst_x   = '0;
    bus.i_net_dst_y   = '0;
    bus.i_net_payload = '0;
    bus.i_rx_ready    = 1'b1;

    tick();
    tick();
    check("rst_tx_ready",  64'(bus.o_tx_ready),  64'd0);
    check("rst_net_valid", 64'(bus.o_net_valid), 64'd0);
    check("rst_rx_valid",  64'(bus.o_rx_valid),  64'd0);
`ifdef MESH_NI_CHECK_EN
    check("rst_err", 64'(err), 64'd0);
`endif
    rst_n = 1'b1;
    #1;
    check("idle_tx_ready",  64'(bus.o_tx_ready),  64'd1);
    check("idle_net_ready", 64'(bus.o_net_ready), 64'd1);

    tx_run("tx1", 32'hDDCCBBAA, 2'd3, 2'd0);

    // Stalled TX: ready 1,0,1,0,...; payload must hold while stalled.
    ms = 32'hDDCCBBAA;
    bus.i_tx_msg   = ms;
    bus.i_tx_valid = 1'b1;
    tick();
    bus.i_tx_valid = 1'b0;
    idx = 0;
    for (int c = 0; c < 20 && idx < MF; c++) begin
      rdy = (c % 2 == 0);
      bus.i_net_ready = rdy;
      #1;
      check($sformatf("stall_valid_c%0d", c), 64'(bus.o_net_valid), 64'd1);
      check($sformatf("stall_flit_c%0d", c), 64'(bus.o_net_payload),
            64'(mk(idx == MF-1, 2'd1, 2'd2, byte_of(ms, idx))));
      tick();
      if (rdy) idx++;
    end
    check("stall_flit_count", 64'(idx), 64'(MF));
    check("stall_done_valid", 64'(bus.o_net_valid), 64'd0);
    bus.i_net_ready = 1'b1;

    // Interleaved reassembly from (0,0) and (2,1).
    for (int k = 0; k < MF; k++) begin
      net_send(mk(k == MF-1, 2'd0, 2'd0, byte_of(ma, k)), 2'd1, 2'd2);
      if (k == MF-1) check_rx("il_a", ma, 2'd0, 2'd0);
      net_send(mk(k == MF-1, 2'd2, 2'd1, byte_of(mb, k)), 2'd1, 2'd2);
    end
    check_rx("il_b", mb, 2'd2, 2'd1);
    tick();
    check("il_drained", 64'(bus.o_rx_valid), 64'd0);

    // Back-pressure: pending message blocks the next last flit; drain + completion back-to-back.
    bus.i_rx_ready = 1'b0;
    for (int k = 0; k < MF-1; k++) net_send(mk(1'b0, 2'd2, 2'd1, byte_of(mb, k)), 2'd1, 2'd2);
    for (int k = 0; k < MF; k++) net_send(mk(k == MF-1, 2'd0, 2'd0, byte_of(ma, k)), 2'd1, 2'd2);
    check_rx("bp_a", ma, 2'd0, 2'd0);
    check("bp_net_ready_low", 64'(bus.o_net_ready), 64'd0);
    bus.i_net_valid   = 1'b1;
    bus.i_net_payload = mk(1'b1, 2'd2, 2'd1, byte_of(mb, MF-1));
    tick();
    tick();
    check("bp_held_msg", 64'(bus.o_rx_msg), 64'(ma));
    check("bp_still_blocked", 64'(bus.o_net_ready), 64'd0);
    bus.i_rx_ready = 1'b1;
    #1;
    check("bp_ready_on_drain", 64'(bus.o_net_ready), 64'd1);
    tick();
    bus.i_net_valid = 1'b0;
    check_rx("bp_b2b", mb, 2'd2, 2'd1);
    tick();
    check("bp_drained", 64'(bus.o_rx_valid), 64'd0);

    // Reset mid-message on both paths, then a fresh message each way.
    net_send(mk(1'b0, 2'd0, 2'd0, 8'hC0), 2'd1, 2'd2);
    net_send(mk(1'b0, 2'd0, 2'd0, 8'hC1), 2'd1, 2'd2);
    bus.i_tx_msg   = 32'h0A0B0C0D;
    bus.i_tx_valid = 1'b1;
    tick();
    bus.i_tx_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_tx_ready", 64'(bus.o_tx_ready), 64'd0);
    tick();
    check("midrst_net_valid", 64'(bus.o_net_valid), 64'd0);
    rst_n = 1'b1;
    tx_run("tx2", 32'hF3F2F1F0, 2'd0, 2'd3);
    for (int k = 0; k < MF; k++)
      net_send(mk(k == MF-1, 2'd0, 2'd0, byte_of(32'hD3D2D1D0, k)), 2'd1, 2'd2);
    check_rx("post_rst", 32'hD3D2D1D0, 2'd0, 2'd0);
    tick();

`ifdef MESH_NI_CHECK_EN
    check("chk_err_clear", 64'(err), 64'd0);
    net_send(mk(1'b1, 2'd0, 2'd0, 8'h5A), 2'd3, 2'd3);
    check("chk_misroute_err", 64'(err), 64'd1);
    check("chk_misroute_drop", 64'(bus.o_rx_valid), 64'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("chk_err_reset", 64'(err), 64'd0);
    net_send(mk(1'b0, 2'd3, 2'd3, 8'h01), 2'd1, 2'd2);
    check("chk_no_err_yet", 64'(err), 64'd0);
    net_send(mk(1'b1, 2'd3, 2'd3, 8'h02), 2'd1, 2'd2);
    check("chk_short_err", 64'(err), 64'd1);
    check("chk_short_delivered", 64'(bus.o_rx_valid), 64'd1);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mesh_ni.md
Name: mesh_ni

Overview:
- Network interface for the local port of one mesh router tile.
- TX path: takes a wide message plus destination coordinates and serializes it into PW-bit flits. Flits are injected into the router's local input.
- RX path: takes flits from the router's local output and reassembles them per source tile. Completed messages are presented with their source coordinates.
- XY routing is deterministic and in-order per source/destination pair, so per-source reassembly needs no reordering.

Parameters:
- PW, 8, data bits per flit
- MSG_FLITS, 4, flits per message (>=1)
- X_SIZE, 4, mesh columns
- Y_SIZE, 4, mesh rows
- XW, $clog2(X_SIZE), x coordinate width (derived, localparam)
- YW, $clog2(Y_SIZE), y coordinate width (derived, localparam)
- FW, PW+1+XW+YW, flit payload width; the router W must equal FW (derived, localparam)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- i_coord_x  in  XW  this tile x
- i_coord_y  in  YW  this tile y
- i_tx_valid  in  1  message request
- i_tx_dst_x  in  XW  destination x
- i_tx_dst_y  in  YW  destination y
- i_tx_msg  in  MSG_FLITS*PW  message, flit 0 = LSBs
- o_tx_ready  out  1  message accepted when high with i_tx_valid
- o_net_valid  out  1  to router local input
- o_net_dst_x  out  XW
- o_net_dst_y  out  YW
- o_net_payload  out  FW  {last, src_x, src_y, data}
- i_net_ready  in  1
- i_net_valid  in  1  from router local output
- i_net_dst_x  in  XW
- i_net_dst_y  in  YW
- i_net_payload  in  FW
- o_net_ready  out  1
- o_rx_valid  out  1  reassembled message
- o_rx_src_x  out  XW
- o_rx_src_y  out  YW
- o_rx_msg  out  MSG_FLITS*PW
- i_rx_ready  in  1

Behaviour:
- All handshakes: transfer occurs when valid && ready. Valid must not depend on ready. Data is held stable while valid && !ready.
- Reset (rst_n low at posedge):
  - TX FSM goes to IDLE; flit counter = 0.
  - o_net_valid = 0, o_rx_valid = 0.
  - All per-source counters = 0.
  - o_tx_ready = 0 while rst_n low.
  - Reset mid-message discards partial TX and RX state.
- TX FSM states IDLE and SEND:
  - IDLE: o_tx_ready = 1. On accept, latch msg and dst, counter = 0, go to SEND.
  - SEND: o_tx_ready = 0, o_net_valid = 1. Payload is {last = (counter == MSG_FLITS-1), i_coord_x, i_coord_y, msg[counter*PW +: PW]}.
  - On each net handshake, counter increments. The handshake on the last flit returns the FSM to IDLE.
  - First flit appears 1 cycle after message accept. With no stall, one message costs MSG_FLITS+1 cycles.
- RX:
  - o_net_ready = !o_rx_valid || i_rx_ready. It does not depend on i_net_valid.
  - Each source s = src_y*X_SIZE + src_x has a (MSG_FLITS-1)*PW buffer and a flit count.
  - Accepted non-last flit: data is stored at buf[s][count*PW +: PW]; count increments.
  - Accepted last flit:
    - o_rx_msg = {data, buf[s]}; o_rx_src = src; o_rx_valid = 1 next cycle; count[s] = 0.
    - Interleaved flits from different sources accumulate independently.
  - o_rx_valid clears on an i_rx_ready handshake unless a new last flit completes in the same cycle (back-to-back delivery).
  - MSG_FLITS = 1: every flit is last; no buffer is instantiated.
  - A last flit arriving with count != MSG_FLITS-1 is still delivered; missing flits read as stale buffer contents.

Optional Feature:
- Macro MESH_NI_CHECK_EN.
- Defined: adds output o_err (1 bit, reset 0, sticky until reset). It sets when an accepted flit's i_net_dst_x/i_net_dst_y differ from the tile coordinates, or when a last flit arrives with count != MSG_FLITS-1.
  - Misrouted flits are consumed and dropped: no buffer update, no o_rx_valid.
- Undefined: no o_err port and no checks; dst fields on the RX side are ignored.

Decomposition:
- Shared header/package mesh_ni_pkg:
  - flit field offsets: DATA_LSB = 0, SRC_Y_LSB = PW, SRC_X_LSB = PW+YW, LAST_BIT = FW-1
  - FW computation function
- Sub-module mesh_ni_rx_assembler holds the RX per-source buffers, counters and output register. The TX FSM stays in the top.

Test Plan:
- PW=8, MSG_FLITS=4, tile (1,2), send 0xDDCCBBAA to (3,0), i_net_ready=1 → 4 flits on consecutive cycles.
  - Flit 0 payload {0,1,2,0xAA} … flit 3 {1,1,2,0xDD}; dst = (3,0).
  - o_tx_ready low for 4 cycles, high on the 5th.
- Same send with i_net_ready toggling 1,0,1,0 → payload stable while stalled; the flit sequence is unchanged.
- RX: flits from source (0,0) and source (2,1) interleaved A0,B0,A1,B1,A2,B2,A3,B3 → two messages out, source (0,0) first, each with correct bytes and src coordinates.
- i_rx_ready=0 with a completed message pending → o_net_ready=0. The next last flit is not accepted until drain. A drain and a completion in the same cycle produce back-to-back o_rx_valid.
- Assert rst_n low after 2 of 4 flits on both TX and RX, then send a fresh message → no residue: the new message is reassembled intact.
- MESH_NI_CHECK_EN: inject a flit with dst (3,3) at tile (1,2) → o_err=1, o_rx_valid stays 0. Also check that a last flit after 1 flit sets o_err.
